// File: rtl/requant_stage.sv
// requant_stage: int32 accumulator -> OUT_W TFLite requantization.
// Capture register followed by four arithmetic stages, one global advance.
module requant_stage #(
    parameter int OUT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_acc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    input  logic             cfg_we,
    input  logic [2:0]       cfg_addr,
    input  logic [31:0]      cfg_data,
    output logic             cfg_ready
);

    typedef struct packed {
        logic [31:0] x;
        logic [4:0]  rs;
    } s1_t;

    typedef struct packed {
        logic [63:0] p;
        logic        sat;
        logic [4:0]  rs;
    } s2_t;

    typedef struct packed {
        logic [31:0] h;
        logic [4:0]  rs;
    } s3_t;

    logic signed [31:0] bias;
    logic signed [31:0] mult;
    logic signed [5:0]  shift;
    logic signed [31:0] out_off;
    logic signed [31:0] act_min;
    logic signed [31:0] act_max;

    logic        v0, v1, v2, v3;
    logic [31:0] a0;
    s1_t         s1, s1_d;
    s2_t         s2, s2_d;
    s3_t         s3, s3_d;

    logic adv;
    logic cfg_wr;

    assign adv       = ~out_valid | out_ready;
    assign in_ready  = adv & ~cfg_we;
    assign cfg_ready = ~(v0 | v1 | v2 | v3 | out_valid);
    assign cfg_wr    = cfg_we & cfg_ready;

    // S1: bias add, optional left shift, right-shift amount for S4
    logic [31:0] xb;
    logic        sh_pos;

    assign xb       = a0 + bias;
    assign sh_pos   = ~shift[5] & (shift[4:0] != 5'd0);
    assign s1_d.x   = sh_pos ? (xb << shift[4:0]) : xb;
    assign s1_d.rs  = sh_pos ? 5'd0 : (~shift[4:0] + 5'd1);

    // S2: full 64-bit signed product and the lone overflow case
    logic [63:0] xe, me;

    assign xe       = {{32{s1.x[31]}}, s1.x};
    assign me       = {{32{mult[31]}}, mult};
    assign s2_d.p   = xe * me;
    assign s2_d.sat = (s1.x == 32'h8000_0000) &&
                      (mult == 32'h8000_0000);
    assign s2_d.rs  = s1.rs;

    // S3: rounding doubling high multiply, truncating toward zero
    logic [63:0] nudge, sum, adj;

    assign nudge   = s2.p[63] ? 64'hFFFF_FFFF_C000_0001
                              : 64'h0000_0000_4000_0000;
    assign sum     = s2.p + nudge;
    assign adj     = sum + (sum[63] ? 64'h7FFF_FFFF : 64'd0);
    assign s3_d.h  = s2.sat ? 32'h7FFF_FFFF : adj[62:31];
    assign s3_d.rs = s2.rs;

    // S4: rounding right shift, output offset, activation clamp
    logic [31:0]        mask, rem, thr;
    logic               rnd;
    logic signed [31:0] sra, r, y, clamp;

    assign mask = (32'd1 << s3.rs) - 32'd1;
    assign rem  = s3.h & mask;
    assign thr  = (mask >> 1) + {31'd0, s3.h[31]};
    assign rnd  = rem > thr;
    assign sra  = $signed(s3.h) >>> s3.rs;
    assign r    = sra + $signed({31'd0, rnd});
    assign y    = r + out_off;

    // Clamp; an inverted range collapses to act_max
    always_comb begin
        clamp = y;
        if (act_min > act_max)
            clamp = act_max;
        else if (y < act_min)
            clamp = act_min;
        else if (y > act_max)
            clamp = act_max;
    end

    logic unused_bits;
    assign unused_bits = ^{adj[63], adj[30:0], clamp[31:OUT_W]};

    // Config registers; writes land only while the pipe is empty
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bias    <= 32'sd0;
            mult    <= 32'sh4000_0000;
            shift   <= 6'sd1;
            out_off <= 32'sd0;
            act_min <= -32'sd128;
            act_max <= 32'sd127;
        end else if (cfg_wr) begin
            case (cfg_addr)
                3'd0: bias    <= cfg_data;
                3'd1: mult    <= cfg_data;
                3'd2: shift   <= cfg_data[5:0];
                3'd3: out_off <= cfg_data;
                3'd4: act_min <= cfg_data;
                3'd5: act_max <= cfg_data;
                default: ;
            endcase
        end
    end

    // Pipeline registers; every rank moves together on adv
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v0        <= 1'b0;
            v1        <= 1'b0;
            v2        <= 1'b0;
            v3        <= 1'b0;
            out_valid <= 1'b0;
            a0        <= 32'd0;
            s1        <= '0;
            s2        <= '0;
            s3        <= '0;
            out_data  <= '0;
        end else if (adv) begin
            v0        <= in_valid & in_ready;
            a0        <= in_acc;
            v1        <= v0;
            s1        <= s1_d;
            v2        <= v1;
            s2        <= s2_d;
            v3        <= v2;
            s3        <= s3_d;
            out_valid <= v3;
            out_data  <= clamp[OUT_W-1:0];
        end
    end

endmodule

// File: tb/tb_requant_stage.sv
// tb_requant_stage: directed vectors with a queue scoreboard.
// Stimulus pushes expected results; the monitor pops on handshake.
`timescale 1ns/1ps
module tb_requant_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_acc;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic        cfg_we;
    logic [2:0]  cfg_addr;
    logic [31:0] cfg_data;
    logic        cfg_ready;

    int checks   = 0;
    int failures = 0;
    logic [7:0] expq[$];

    requant_stage #(.OUT_W(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_acc    (in_acc),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_data  (cfg_data),
        .cfg_ready (cfg_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        failures++;
        $display("FAIL %s actual=timeout required=event", name);
    endtask

    // Monitor: compare head while valid, pop on handshake
    always @(negedge clk) begin
        #3;
        if (!reset && out_valid) begin
            if (expq.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_output actual=%0h required=none",
                         out_data);
            end else begin
                check("out_data", 32'(out_data), 32'(expq[0]));
                if (!out_ready)
                    check("stall_in_ready", 32'(in_ready), 32'd0);
                else
                    void'(expq.pop_front());
            end
        end
    end

    task automatic send(input logic [31:0] acc, input logic [7:0] exp);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_acc   = acc;
            #4;
            if (in_ready) begin
                @(posedge clk);
                expq.push_back(exp);
                #1 in_valid = 1'b0;
                return;
            end
        end
        timeout("send");
        in_valid = 1'b0;
    endtask

    task automatic cfg_write(input logic [2:0] addr, input logic [31:0] data);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            #4;
            if (cfg_ready) begin
                cfg_we   = 1'b1;
                cfg_addr = addr;
                cfg_data = data;
                @(posedge clk);
                #1 cfg_we = 1'b0;
                return;
            end
        end
        timeout("cfg_write");
    endtask

    task automatic drain();
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            #4;
            if (expq.size() == 0 && cfg_ready)
                return;
        end
        timeout("drain");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    bit seen;

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_acc    = 32'd0;
        out_ready = 1'b1;
        cfg_we    = 1'b0;
        cfg_addr  = 3'd0;
        cfg_data  = 32'd0;
        #2;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_cfg_ready", 32'(cfg_ready), 32'd1);
        #10 reset = 1'b0;

        // Latency: valid appears right after the 4th edge
        send(32'd7, 8'd7);
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk);
            #1;
            check("latency", 32'(out_valid), 32'(k == 4));
        end
        drain();

        // Identity defaults with clamping
        send(32'd100, 8'd100);
        send(32'hFFFF_FFCE, 8'hCE);
        send(32'd1000, 8'h7F);
        send(32'hFFFF_FC18, 8'h80);
        drain();

        // Rounding, shift -1 then shift 0
        cfg_write(3'd2, 32'hFFFF_FFFF);
        send(32'd6, 8'd2);
        send(32'hFFFF_FFFA, 8'hFE);
        cfg_write(3'd2, 32'd0);
        send(32'd3, 8'd2);
        send(32'hFFFF_FFFD, 8'hFF);
        drain();

        // Saturating multiply with full-range clamp
        cfg_write(3'd1, 32'h8000_0000);
        cfg_write(3'd4, 32'h8000_0000);
        cfg_write(3'd5, 32'h7FFF_FFFF);
        send(32'h8000_0000, 8'hFF);
        cfg_write(3'd1, 32'h4000_0000);
        cfg_write(3'd2, 32'd1);
        cfg_write(3'd4, 32'hFFFF_FF80);
        cfg_write(3'd5, 32'd127);

        // Output offset
        cfg_write(3'd3, 32'hFFFF_FF80);
        send(32'd10, 8'h8A);
        cfg_write(3'd3, 32'd0);

        // Bias, then inverted activation range
        cfg_write(3'd0, 32'd5);
        send(32'd10, 8'd15);
        cfg_write(3'd4, 32'd10);
        cfg_write(3'd5, 32'd5);
        send(32'd100, 8'd5);
        cfg_write(3'd0, 32'd0);
        cfg_write(3'd4, 32'hFFFF_FF80);
        cfg_write(3'd5, 32'd127);
        drain();

        // Backpressure: 5 stalled cycles after first valid
        out_ready = 1'b0;
        seen = 1'b0;
        fork
            begin : bp_src
                for (int i = 1; i <= 6; i++)
                    send(32'(i * 11), 8'(i * 11));
            end
            begin : bp_sink
                for (int c = 0; c < 100 && !seen; c++) begin
                    @(negedge clk);
                    #4;
                    seen = out_valid;
                end
                check("bp_first_valid", 32'(seen), 32'd1);
                repeat (5) @(negedge clk);
                out_ready = 1'b1;
            end
        join
        drain();

        // Config write while busy is dropped
        send(32'd20, 8'd20);
        send(32'd21, 8'd21);
        @(negedge clk);
        cfg_we   = 1'b1;
        cfg_addr = 3'd0;
        cfg_data = 32'd1000;
        #4;
        check("busy_cfg_ready", 32'(cfg_ready), 32'd0);
        @(posedge clk);
        #1 cfg_we = 1'b0;
        drain();
        send(32'd22, 8'd22);
        drain();

        // Config write on empty pipe blocks input that cycle
        @(negedge clk);
        cfg_we   = 1'b1;
        cfg_addr = 3'd0;
        cfg_data = 32'd7;
        in_valid = 1'b1;
        in_acc   = 32'd1;
        #4;
        check("gate_in_ready", 32'(in_ready), 32'd0);
        check("gate_cfg_ready", 32'(cfg_ready), 32'd1);
        @(posedge clk);
        #1 cfg_we = 1'b0;
        send(32'd1, 8'd8);
        drain();
        cfg_write(3'd0, 32'd0);

        // Async reset with three elements in flight
        cfg_write(3'd3, 32'd50);
        send(32'd1, 8'd51);
        send(32'd2, 8'd52);
        send(32'd3, 8'd53);
        @(posedge clk);
        @(posedge clk);
        #2;
        check("pre_reset_valid", 32'(out_valid), 32'd1);
        reset = 1'b1;
        #1;
        check("async_out_valid", 32'(out_valid), 32'd0);
        check("async_cfg_ready", 32'(cfg_ready), 32'd1);
        expq.delete();
        #4 reset = 1'b0;
        repeat (8) @(negedge clk);
        #4;
        check("post_reset_idle", 32'(out_valid), 32'd0);
        send(32'd5, 8'd5);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
